match_detector: RTL and testbench

MATCH_DETECTOR -- requirements
Module: match_detector

---
 rtl/match_detector.sv | 93 +++++++++
 tb/tb_match_detector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/match_detector.sv
// Serial MSB-first pattern matcher: masked window compare, saturating match
// counter, and a byte-wide valid/ready output port with a sticky overrun flag.
module match_detector #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [PAT_W-1:0] out_data,
  output logic             out_match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             overrun
);
  localparam int BC_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BC_W-1:0]  LAST    = BC_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {FILL, RUN} state_t;

  state_t           state;
  logic [PAT_W-1:0] window, pattern, mask;
  logic [BC_W-1:0]  bit_cnt;

  logic             accept, hit, byte_done, fire;
  logic [PAT_W-1:0] window_next;

  always_comb begin
    accept      = ena & bit_valid & ~cfg_load;
    window_next = {window[PAT_W-2:0], bit_in};
    hit         = ((window_next ^ pattern) & mask) == '0;
    byte_done   = accept && (bit_cnt == LAST);
    // In FILL the byte boundary is exactly the bit that completes the window
    fire        = accept && hit && ((state == RUN) || byte_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      window      <= '0;
      pattern     <= '0;
      mask        <= '1;
      bit_cnt     <= '0;
      out_data    <= '0;
      out_match   <= 1'b0;
      out_valid   <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      overrun     <= 1'b0;
    end else if (cfg_load) begin
      state       <= FILL;
      window      <= '0;
      pattern     <= cfg_pattern;
      mask        <= cfg_mask;
      bit_cnt     <= '0;
      out_valid   <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      overrun     <= 1'b0;
    end else begin
      match <= fire;
      if (fire && match_count != CNT_MAX)
        match_count <= match_count + 1'b1;

      if (accept) begin
        window  <= window_next;
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        if (byte_done)
          state <= RUN;
      end

      // A completing byte always wins; it only counts as overrun if the
      // previous byte was still waiting and not taken this cycle.
      if (byte_done) begin
        out_data  <= window_next;
        out_match <= hit;
        out_valid <= 1'b1;
        if (out_valid && !out_ready)
          overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_match_detector.sv
// Directed and random stimulus for match_detector, checked each cycle against
// a bit-count based reference model.
module tb_match_detector;
  logic       clk = 1'b0;
  logic       rst, ena, cfg_load, bit_in, bit_valid, out_ready;
  logic [7:0] cfg_pattern, cfg_mask;
  logic [7:0] out_data, match_count;
  logic       out_match, out_valid, match, overrun;

  int tests = 0;
  int fails = 0;

  // reference model state
  int         m_n, m_cnt;
  logic [7:0] m_win, m_pat, m_mask, m_od;
  logic       m_om, m_ov, m_ovr, m_match;

  match_detector #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_match(out_match), .out_valid(out_valid),
    .out_ready(out_ready), .match(match), .match_count(match_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_data",    32'(out_data),    32'(m_od));
    chk("out_match",   32'(out_match),   32'(m_om));
    chk("out_valid",   32'(out_valid),   32'(m_ov));
    chk("match",       32'(match),       32'(m_match));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("overrun",     32'(overrun),     32'(m_ovr));
  endtask

  task automatic model_reset();
    m_n = 0; m_cnt = 0; m_win = 8'h00; m_pat = 8'h00; m_mask = 8'hFF;
    m_od = 8'h00; m_om = 1'b0; m_ov = 1'b0; m_ovr = 1'b0; m_match = 1'b0;
  endtask

  // One clock edge of the reference behaviour, from the inputs sampled there.
  task automatic model_edge();
    logic h;
    if (cfg_load) begin
      m_pat = cfg_pattern; m_mask = cfg_mask;
      m_n = 0; m_win = 8'h00; m_match = 1'b0; m_cnt = 0;
      m_ov = 1'b0; m_ovr = 1'b0;
    end else begin
      m_match = 1'b0;
      if (ena && bit_valid) begin
        m_win = {m_win[6:0], bit_in};
        m_n++;
        h = ((m_win ^ m_pat) & m_mask) == 8'h00;
        if (m_n >= 8 && h) begin
          m_match = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        if (m_n % 8 == 0) begin
          if (m_ov && !out_ready) m_ovr = 1'b1;
          m_od = m_win; m_om = h; m_ov = 1'b1;
        end else if (m_ov && out_ready) m_ov = 1'b0;
      end else if (m_ov && out_ready) m_ov = 1'b0;
    end
  endtask

  task automatic cyc(input logic e, input logic cl, input logic bv, input logic b, input logic rdy);
    ena = e; cfg_load = cl; bit_valid = bv; bit_in = b; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] m);
    cfg_pattern = p; cfg_mask = m;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic shift_byte(input logic [7:0] v, input logic rdy);
    for (int i = 7; i >= 0; i--) cyc(1'b1, 1'b0, 1'b1, v[i], rdy);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; cfg_load = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    out_ready = 1'b0; cfg_pattern = 8'h00; cfg_mask = 8'h00;
    model_reset();
    #2;
    check_all();
    @(negedge clk) rst = 1'b0;

    // exact byte match
    load(8'hA5, 8'hFF);
    shift_byte(8'hA5, 1'b1);
    chk("a5_match", 32'(match), 32'd1);
    chk("a5_data",  32'(out_data), 32'hA5);
    chk("a5_cnt",   32'(match_count), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // run of ones keeps matching every bit once RUN
    load(8'hFF, 8'hFF);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("ones_cnt", 32'(match_count), 32'd3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // backpressure and overrun
    load(8'h00, 8'hFF);
    shift_byte(8'h12, 1'b0);
    shift_byte(8'h34, 1'b0);
    chk("ovr_data", 32'(out_data), 32'h34);
    chk("ovr_flag", 32'(overrun), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drain", 32'(out_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // mask 0: saturation, then ena low freezes everything
    load(8'h3C, 8'h00);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    chk("sat_cnt", 32'(match_count), 32'd255);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // cfg_load mid-byte discards its own bit and restarts the byte count
    load(8'hC3, 8'hFF);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cfg_pattern = 8'hC3; cfg_mask = 8'hFF;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    shift_byte(8'hC3, 1'b1);
    chk("reload_valid", 32'(out_valid), 32'd1);
    chk("reload_match", 32'(out_match), 32'd1);

    // async reset between edges with a byte pending
    load(8'h55, 8'hFF);
    shift_byte(8'h55, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
    // pattern 0 / mask all-ones after reset: zeros match, a trailing one does not
    shift_byte(8'h00, 1'b1);
    chk("rst_zero_match", 32'(out_match), 32'd1);
    shift_byte(8'h01, 1'b1);
    chk("rst_one_nomatch", 32'(out_match), 32'd0);

    // random traffic with occasional reconfiguration
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(63) == 0) begin
        cfg_pattern = 8'($urandom); cfg_mask = 8'($urandom & $urandom);
        cyc(1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end else begin
        cyc($urandom_range(3) != 0, 1'b0, $urandom_range(3) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
